// File: rtl/blink_checker.sv
// blink_checker: measures the edge-to-edge interval of an asynchronous toggle
// input and reports lock when LOCK_N consecutive intervals land inside
// EXP_HALF +/- TOL. It faults on an out-of-window interval or a missing edge
// while locked.
// Optional build macro BLINK_CHECK_AUTORECOVER_EN: the first edge seen in
// FAULT returns the checker to acquisition. Without it, FAULT is left only
// through rst.
module blink_checker #(
  parameter int CNT_W    = 27,
  parameter int EXP_HALF = 67108864,
  parameter int TOL      = 1024,
  parameter int LOCK_N   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  output logic             locked,
  output logic             fault,
  output logic [CNT_W-1:0] half_period
);

  localparam int MATCH_W = $clog2(LOCK_N + 1);

  // Window bounds are one bit wider than the counter so EXP_HALF+TOL cannot
  // wrap. The low bound clamps at zero.
  localparam logic [CNT_W:0] WIN_LO =
    (EXP_HALF > TOL) ? (CNT_W+1)'(EXP_HALF - TOL) : '0;
  localparam logic [CNT_W:0] WIN_HI = (CNT_W+1)'(EXP_HALF + TOL);
  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(EXP_HALF + TOL + 1);
  localparam logic [MATCH_W-1:0] LOCK_CNT = MATCH_W'(LOCK_N);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   half_q;
  logic               s1_q, s2_q, s3_q;
  logic               locked_q, fault_q;

  logic               edge_s;
  logic [CNT_W:0]     meas_w;
  logic               in_win;
  logic               timeout;

  assign edge_s  = s2_q ^ s3_q;
  assign meas_w  = {1'b0, cnt_q};
  assign in_win  = (meas_w >= WIN_LO) && (meas_w <= WIN_HI);
  assign timeout = (meas_w >= TO_LIM);

  // Two-flop synchronizer, plus a history flop used to detect either edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= blink_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Interval counter: on an edge, latch the interval and restart at 1.
  // Otherwise count up and hold at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= '0;
    end else if (edge_s) begin
      half_q <= cnt_q;
      cnt_q  <= CNT_W'(1);
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // State, match counter and output registers. The outputs decode the next
  // state, so they change in the same cycle as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      match_q  <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      locked_q <= (state_d == ST_LOCKED);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  // Next-state logic. An edge arriving in the timeout cycle is judged as a
  // measurement. Its value is already out of window, so both paths give FAULT.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_s) begin
          state_d = ST_ACQ;
          match_d = '0;
        end
      end
      ST_ACQ: begin
        if (edge_s) begin
          if (in_win) begin
            match_d = match_q + MATCH_W'(1);
            if (match_q + MATCH_W'(1) == LOCK_CNT) begin
              state_d = ST_LOCKED;
            end
          end else begin
            match_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (edge_s) begin
          if (!in_win) begin
            state_d = ST_FAULT;
          end
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
`ifdef BLINK_CHECK_AUTORECOVER_EN
        if (edge_s) begin
          state_d = ST_ACQ;
          match_d = '0;
        end
`else
        state_d = ST_FAULT;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        match_d = '0;
      end
    endcase
  end

  assign locked      = locked_q;
  assign fault       = fault_q;
  assign half_period = half_q;

endmodule

// File: tb/tb_blink_checker.sv
module tb_blink_checker;

  localparam int CNT_W  = 8;
  localparam int EXP    = 16;
  localparam int TOL    = 2;
  localparam int LOCK_N = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             blink_in = 1'b0;
  logic             locked;
  logic             fault;
  logic [CNT_W-1:0] half_period;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_tog = 0;

  // Reference model, kept in terms of intervals between input toggles.
  bit m_seen, m_lk, m_ft, m_hp_valid;
  int m_run, m_hp;

  blink_checker #(
    .CNT_W(CNT_W), .EXP_HALF(EXP), .TOL(TOL), .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk), .rst(rst), .blink_in(blink_in),
    .locked(locked), .fault(fault), .half_period(half_period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_lk = 0; m_ft = 0; m_hp_valid = 0; m_run = 0; m_hp = 0;
  endtask

  task automatic model_edge(int n);
    bit inwin;
    inwin = (n >= EXP - TOL) && (n <= EXP + TOL);
    if (!m_seen) begin
      m_seen = 1;
      m_run  = 0;
    end else begin
      m_hp = (n > SAT) ? SAT : n;
      m_hp_valid = 1;
      if (m_ft) begin
`ifdef BLINK_CHECK_AUTORECOVER_EN
        m_ft  = 0;
        m_run = 0;
`endif
      end else if (m_lk) begin
        if (n > EXP + TOL + 1) begin
          // A timeout already faulted before this edge arrived.
          m_lk = 0;
`ifdef BLINK_CHECK_AUTORECOVER_EN
          m_run = 0;
`else
          m_ft = 1;
`endif
        end else if (!inwin) begin
          m_lk = 0;
          m_ft = 1;
        end
      end else begin
        m_run = inwin ? m_run + 1 : 0;
        if (m_run == LOCK_N) m_lk = 1;
      end
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    blink_in = 1'b0;
    tick(2);
    chk({tag, "_rst_locked"}, int'(locked), 0);
    chk({tag, "_rst_fault"}, int'(fault), 0);
    chk({tag, "_rst_hp"}, int'(half_period), 0);
    rst = 1'b0;
    model_reset();
    tick(2);
    last_tog = cyc;
  endtask

  // Toggle so that the interval since the previous toggle is n cycles, then
  // check once the edge has been registered.
  task automatic edge_after(int n, string tag);
    tick(n - 3);
    blink_in = ~blink_in;
    model_edge(cyc - last_tog);
    last_tog = cyc;
    tick(3);
    chk({tag, "_locked"}, int'(locked), int'(m_lk));
    chk({tag, "_fault"}, int'(fault), int'(m_ft));
    if (m_hp_valid) chk({tag, "_hp"}, int'(half_period), m_hp);
  endtask

  initial begin
    int tol_seq[4];
    int acq_seq[8];
    int r, n;
    tol_seq = '{18, 14, 17, 19};
    acq_seq = '{16, 16, 16, 25, 16, 16, 16, 16};

    // Reset state, then quiet input.
    do_reset("init");
    tick(50);
    chk("idle_locked", int'(locked), 0);
    chk("idle_fault", int'(fault), 0);

    // Lock, tolerance, then an interval just outside the window.
    do_reset("tol");
    repeat (6) edge_after(EXP, "lock");
    chk("lock_direct", int'(locked), 1);
    foreach (tol_seq[i]) edge_after(tol_seq[i], "tol");
    chk("tol_fault_direct", int'(fault), 1);
    // Recovery attempt: recovers only in the auto-recover build.
    repeat (5) edge_after(EXP, "cfg");

    // Timeout while locked, then a saturated measurement.
    do_reset("to");
    repeat (6) edge_after(EXP, "to_lock");
    tick(EXP + TOL);
    chk("to_before_fault", int'(fault), 0);
    chk("to_before_locked", int'(locked), 1);
    tick(1);
    chk("to_fault", int'(fault), 1);
    chk("to_locked", int'(locked), 0);
    edge_after(300 - (EXP + TOL + 1) - 3 + 3, "sat");
    chk("sat_hp_direct", int'(half_period), SAT);

    // A bad interval during acquisition restarts the match count.
    do_reset("acq");
    edge_after(EXP, "acq_first");
    foreach (acq_seq[i]) edge_after(acq_seq[i], "acq");
    chk("acq_lock_direct", int'(locked), 1);

    // An asynchronous reset clears the outputs without a clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_fault", int'(fault), 0);
    chk("async_hp", int'(half_period), 0);
    tick(1);
    rst = 1'b0;
    model_reset();
    tick(2);
    last_tog = cyc;

    // Randomized intervals, mostly in-window with some outliers.
    for (int run = 0; run < 4; run++) begin
      do_reset("rnd");
      edge_after(EXP, "rnd_first");
      for (int i = 0; i < 14; i++) begin
        r = $urandom_range(0, 9);
        if (r < 7) n = $urandom_range(EXP - TOL, EXP + TOL);
        else n = $urandom_range(8, 30);
        edge_after(n, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blink_checker.md
# blink_checker

Receive-side companion to the siren clock divider: samples an asynchronous blink/toggle input (e.g. a divider-driven LED line looped back), measures the cycle count between successive edges, and reports whether the signal is toggling at the expected half-period. Sits on the board-test path next to the siren. It provides a self-check that the divider chain is running at the intended rate.

## Interface
- CNT_W, 27: width of the interval counter and `half_period` output.
- EXP_HALF, 67108864 (2^26): expected clock cycles between consecutive edges.
- TOL, 1024: allowed deviation in cycles. A measurement is in-window when EXP_HALF−TOL ≤ m ≤ EXP_HALF+TOL.
- LOCK_N, 4: consecutive in-window measurements required to lock.

Ports:
- clk  in  1  system clock. The only clock in the block.
- rst  in  1  reset. Asynchronous, active-high. Clears all state.
- blink_in  in  1  asynchronous toggle input.
- locked  out  1  high while in LOCKED.
- fault  out  1  high while in FAULT.
- half_period  out  CNT_W  last measured edge-to-edge interval, in cycles.

## Operation
- Input path:
  - 2-FF synchronizer: `s1`, `s2`.
  - History flop `s3` <= `s2`.
  - Edge pulse: `edge = s2 ^ s3`. Both rising and falling edges count.
- Interval counter `cnt`:
  - On an edge cycle: `half_period <= cnt`, `cnt <= 1`.
  - Otherwise: `cnt <= cnt + 1`, saturating at all-ones (no wrap).
  - The measured value equals the number of clk cycles between edges.
- Match counter `match`, width clog2(LOCK_N+1).
- State machine:
  - IDLE (reset state):
    - First edge -> ACQ with `match = 0`.
    - The first measurement is discarded, because the start point is unknown.
  - ACQ:
    - In-window edge: `match++`. When `match` reaches LOCK_N -> LOCKED.
    - Out-of-window edge: `match = 0`, stay in ACQ.
    - No timeout in ACQ.
  - LOCKED:
    - In-window edge: stay.
    - Out-of-window edge -> FAULT.
    - Timeout -> FAULT. Timeout means no edge while `cnt` reaches EXP_HALF+TOL+1.
  - FAULT: behaviour set by the Configuration macro.
- Outputs are registered decodes of the state: `locked = (state==LOCKED)`, `fault = (state==FAULT)`. They are never both high.
- Window comparison uses CNT_W+1-bit arithmetic, so EXP_HALF±TOL cannot overflow or underflow.
- Reset values: `locked = 0`, `fault = 0`, `half_period = 0`, `cnt = 0`, `match = 0`, state IDLE, `s1`/`s2`/`s3 = 0`.

## Timing
- Synchronizer latency: a `blink_in` change becomes visible as `edge` in the cycle after the second clk rising edge. `half_period` and state update on the third rising edge.
- Edge-to-edge measurement is unaffected by this fixed latency.
- `locked` rises the cycle after the LOCK_N-th in-window edge following the first edge, i.e. on edge number LOCK_N+1.
- Timeout fault: `fault` rises the cycle after `cnt` equals EXP_HALF+TOL+1.
- Edge coinciding with timeout: the edge wins. It is evaluated as a measurement, and its value is out-of-window, so the result is still FAULT.
- `rst` mid-operation: all outputs clear immediately (asynchronous), with no clk needed. After release, the block restarts from IDLE.
- Pulses on `blink_in` shorter than one clk period may be missed. This is acceptable.

## Configuration
- BLINK_CHECK_AUTORECOVER_EN defined:
  - From FAULT, the next edge moves to ACQ with `match = 0`.
  - `fault` drops the cycle after that edge. Relock then follows the normal ACQ rules.
- Undefined (default):
  - FAULT is sticky. Only `rst` leaves it.

## Test plan
Unless noted, tests use CNT_W=8, EXP_HALF=16, TOL=2, LOCK_N=4.
- Reset check: assert `rst` with `blink_in` idle -> `locked = 0`, `fault = 0`, `half_period = 0`. Hold 50 cycles with no edges -> still IDLE, no fault.
- Lock: toggle `blink_in` every 16 cycles -> `half_period = 16` from the 2nd edge on. `locked` rises after the 5th edge. `fault` stays 0.
- Tolerance:
  - After lock, intervals 18, 14, 17 -> stays locked, `half_period` tracks each value.
  - Then an interval of 19 -> `fault = 1`, `locked = 0`.
- Timeout and saturation:
  - After lock, hold `blink_in` constant -> `fault` rises 19 cycles after the last edge.
  - Hold 300 cycles, then toggle -> `half_period = 255` (saturated).
- ACQ reset: intervals 16, 16, 16, 25, 16, 16, 16, 16 -> no lock after the 25, `locked` rises after the final 16.
- Config and reset:
  - With BLINK_CHECK_AUTORECOVER_EN, after a fault apply five 16-cycle intervals -> `fault` drops, `locked` returns.
  - Without the macro, the same stimulus -> `fault` stays 1.
  - Async `rst` pulse mid-clock while locked -> outputs 0 before the next clk edge.
